// File: rtl/lcd_seq_pkg.sv
// -----------------------------------------------------------------------------
// lcd_seq_pkg
// Shared definitions for the LCD panel power sequencer:
//   - seq_state_e : sequencer state encoding (also exported on oSTATE)
//   - dly_min1()  : clamps a programmed stage delay to at least one cycle
//   - stage_slice(): extracts the per-stage delay field from the packed
//                    delay parameter vector
// -----------------------------------------------------------------------------
package lcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_UP   = 2'd1,
        ST_ON   = 2'd2,
        ST_DOWN = 2'd3
    } seq_state_e;

    localparam int MAX_STAGES = 8;
    localparam int MAX_CNT_W  = 32;
    localparam int MAX_VEC_W  = MAX_STAGES * MAX_CNT_W;

    // A programmed delay of zero would make the counter compare against -1,
    // so it is treated as a single cycle instead.
    function automatic logic [MAX_CNT_W-1:0] dly_min1(input logic [MAX_CNT_W-1:0] d);
        return (d == '0) ? MAX_CNT_W'(1) : d;
    endfunction

    // Field k of a vector packed as w-bit slices, slice 0 in the LSBs.
    function automatic logic [MAX_CNT_W-1:0] stage_slice(
        input logic [MAX_VEC_W-1:0] vec,
        input int                   k,
        input int                   w
    );
        logic [MAX_CNT_W-1:0] r;
        r = '0;
        for (int b = 0; b < MAX_CNT_W; b++) begin
            if (b < w) begin
                r[b] = vec[k*w + b];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lcd_clk_div.sv
// -----------------------------------------------------------------------------
// lcd_clk_div
// Free-running power-of-two clock divider. The counter wraps naturally and
// its MSB is a 50% duty clock at i_clk / 2^DIV_LOG2.
// Ports:
//   i_clk  : system clock
//   i_clr  : synchronous clear of the divider counter
//   o_msb  : divided clock (counter MSB, registered)
// -----------------------------------------------------------------------------
module lcd_clk_div #(
    parameter int DIV_LOG2 = 2
) (
    input  logic i_clk,
    input  logic i_clr,
    output logic o_msb
);

    logic [DIV_LOG2-1:0] r_div;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign o_msb = r_div[DIV_LOG2-1];

endmodule

// File: rtl/lcd_power_seq.sv
// -----------------------------------------------------------------------------
// lcd_power_seq
// Power-on / power-off sequencer for the LCD panel. Stage enables are raised
// in ascending order with a per-stage delay and dropped in descending order.
// While the panel is not fully up, its reset is held low and a locally
// divided clock is supplied; once up, host reset and decoded clock pass
// straight through. A request change mid-sequence reverses direction from
// wherever the sequence currently is.
// Ports:
//   iCLK          : system clock
//   iRST          : synchronous reset, active-high
//   iPWR_REQ      : level request, 1 = panel on, 0 = panel off (pre-synchronised)
//   iHC_GREST_n   : host panel reset, forwarded while ON
//   iNCLK_decode  : host decoded panel clock, forwarded while ON
//   oSTAGE_EN     : sequenced enables, bit 0 first on / last off
//   oGREST_n      : panel reset, active-low
//   oNCLK         : panel clock
//   oREADY        : panel fully powered (state ON)
//   oBUSY         : sequence in progress (state UP or DOWN)
//   oSTATE        : OFF=0, UP=1, ON=2, DOWN=3
// -----------------------------------------------------------------------------
module lcd_power_seq
    import lcd_seq_pkg::*;
#(
    parameter int                           NUM_STAGES = 4,
    parameter int                           CNT_W      = 18,
    parameter logic [NUM_STAGES*CNT_W-1:0]  STAGE_DLY  = {NUM_STAGES{CNT_W'(18'h18A60)}},
    parameter int                           DIV_LOG2   = 2
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iPWR_REQ,
    input  logic                  iHC_GREST_n,
    input  logic                  iNCLK_decode,
    output logic [NUM_STAGES-1:0] oSTAGE_EN,
    output logic                  oGREST_n,
    output logic                  oNCLK,
    output logic                  oREADY,
    output logic                  oBUSY,
    output logic [1:0]            oSTATE
);

    localparam int                IDX_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_STAGES - 1);

    seq_state_e             r_state;
    logic [NUM_STAGES-1:0]  r_stage_en;
    logic [IDX_W-1:0]       r_idx;
    logic [CNT_W-1:0]       r_cnt;

    logic [CNT_W-1:0]       w_dly_m1 [NUM_STAGES];
    logic                   w_cnt_done;
    logic [IDX_W-1:0]       w_hi_set;
    logic                   w_any_set;
    logic [IDX_W-1:0]       w_lo_clr;
    logic                   w_all_set;
    logic                   w_div_clr;
    logic                   w_div_msb;

    // Terminal count per stage (D[k]-1), fixed at elaboration.
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_dly
        assign w_dly_m1[k] = CNT_W'(dly_min1(stage_slice(MAX_VEC_W'(STAGE_DLY), k, CNT_W)) - 32'd1);
    end

    assign w_cnt_done = (r_cnt == w_dly_m1[r_idx]);

    // Enables always form a contiguous run from bit 0, so the highest set
    // bit is where a reversal into DOWN resumes and the lowest clear bit is
    // where a reversal into UP resumes.
    always_comb begin
        w_hi_set  = '0;
        w_any_set = 1'b0;
        w_lo_clr  = '0;
        w_all_set = 1'b1;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (r_stage_en[k]) begin
                w_hi_set  = IDX_W'(k);
                w_any_set = 1'b1;
            end
        end
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (!r_stage_en[k]) begin
                w_lo_clr  = IDX_W'(k);
                w_all_set = 1'b0;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state    <= ST_OFF;
            r_stage_en <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    if (iPWR_REQ) begin
                        r_state <= ST_UP;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                    end
                end

                ST_UP: begin
                    // A dropped request wins over a stage advance on the same edge.
                    if (!iPWR_REQ) begin
                        r_cnt <= '0;
                        if (w_any_set) begin
                            r_state <= ST_DOWN;
                            r_idx   <= w_hi_set;
                        end else begin
                            r_state <= ST_OFF;
                            r_idx   <= '0;
                        end
                    end else if (w_cnt_done) begin
                        r_stage_en[r_idx] <= 1'b1;
                        r_cnt             <= '0;
                        if (r_idx == LAST_IDX) begin
                            r_state <= ST_ON;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_ON: begin
                    if (!iPWR_REQ) begin
                        r_state <= ST_DOWN;
                        r_idx   <= LAST_IDX;
                        r_cnt   <= '0;
                    end
                end

                ST_DOWN: begin
                    if (iPWR_REQ) begin
                        r_cnt <= '0;
                        // Request back before anything was cleared: already fully up.
                        if (w_all_set) begin
                            r_state <= ST_ON;
                            r_idx   <= LAST_IDX;
                        end else begin
                            r_state <= ST_UP;
                            r_idx   <= w_lo_clr;
                        end
                    end else if (w_cnt_done) begin
                        r_stage_en[r_idx] <= 1'b0;
                        r_cnt             <= '0;
                        if (r_idx == '0) begin
                            r_state <= ST_OFF;
                        end else begin
                            r_idx <= r_idx - 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_OFF;
                end
            endcase
        end
    end

    // Divider only runs while not OFF so the local clock always starts from
    // a known phase at the beginning of a power-up.
    assign w_div_clr = iRST | (r_state == ST_OFF);

    lcd_clk_div #(
        .DIV_LOG2 (DIV_LOG2)
    ) u_clk_div (
        .i_clk (iCLK),
        .i_clr (w_div_clr),
        .o_msb (w_div_msb)
    );

    assign oSTAGE_EN = r_stage_en;
    assign oSTATE    = r_state;
    assign oREADY    = (r_state == ST_ON);
    assign oBUSY     = (r_state == ST_UP) || (r_state == ST_DOWN);
    assign oGREST_n  = (r_state == ST_ON) ? iHC_GREST_n : 1'b0;

    always_comb begin
        case (r_state)
            ST_ON:          oNCLK = iNCLK_decode;
            ST_UP, ST_DOWN: oNCLK = w_div_msb;
            default:        oNCLK = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_lcd_power_seq.sv
// -----------------------------------------------------------------------------
// tb_lcd_power_seq
// Directed stimulus for lcd_power_seq with NUM_STAGES=3, CNT_W=8,
// delays D0=4, D1=2, D2=1 (slice 2 programmed as 0), DIV_LOG2=2.
// Stimulus code schedules expected output values at absolute cycle numbers
// into a scoreboard; an independent monitor on the falling edge pops and
// compares every entry that has come due.
// -----------------------------------------------------------------------------
module tb_lcd_power_seq;

    localparam int K_EN  = 0;
    localparam int K_ST  = 1;
    localparam int K_RDY = 2;
    localparam int K_BSY = 3;
    localparam int K_GR  = 4;
    localparam int K_NC  = 5;

    typedef struct packed {
        int         cyc;
        int         kind;
        logic [7:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       grest_in;
    logic       nclk_in;
    logic [2:0] en;
    logic       grest_o;
    logic       nclk_o;
    logic       ready;
    logic       busy;
    logic [1:0] st;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];
    exp_t e;
    logic [7:0] act;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lcd_power_seq #(
        .NUM_STAGES (3),
        .CNT_W      (8),
        .STAGE_DLY  ({8'd0, 8'd2, 8'd4}),
        .DIV_LOG2   (2)
    ) dut (
        .iCLK         (clk),
        .iRST         (rst),
        .iPWR_REQ     (req),
        .iHC_GREST_n  (grest_in),
        .iNCLK_decode (nclk_in),
        .oSTAGE_EN    (en),
        .oGREST_n     (grest_o),
        .oNCLK        (nclk_o),
        .oREADY       (ready),
        .oBUSY        (busy),
        .oSTATE       (st)
    );

    function automatic string kind_name(input int kind);
        case (kind)
            K_EN:    return "stage_en";
            K_ST:    return "state";
            K_RDY:   return "ready";
            K_BSY:   return "busy";
            K_GR:    return "grest_n";
            default: return "nclk";
        endcase
    endfunction

    function automatic logic [7:0] observe(input int kind);
        case (kind)
            K_EN:    return {5'b0, en};
            K_ST:    return {6'b0, st};
            K_RDY:   return {7'b0, ready};
            K_BSY:   return {7'b0, busy};
            K_GR:    return {7'b0, grest_o};
            default: return {7'b0, nclk_o};
        endcase
    endfunction

    // Schedule an expected value; kept sorted by cycle.
    task automatic expect_at(input int c, input int kind, input logic [7:0] val);
        exp_t x;
        int   pos;
        x.cyc  = c;
        x.kind = kind;
        x.val  = val;
        pos    = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > c) begin
                pos = i;
                break;
            end
        end
        sb.insert(pos, x);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every scheduled value once its cycle arrives.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = observe(e.kind);
            n_vec++;
            if (e.cyc != cyc || act !== e.val) begin
                n_bad++;
                $display("FAIL %s @cyc %0d (checked at %0d): got %0h, expected %0h",
                         kind_name(e.kind), e.cyc, cyc, act, e.val);
            end
        end
    end

    int c0, u0, t0, r0, u1, v0, w0;

    initial begin
        rst      = 1'b1;
        req      = 1'b0;
        grest_in = 1'b1;
        nclk_in  = 1'b1;

        // Reset state
        tick(2);
        expect_at(cyc, K_EN,  8'd0);
        expect_at(cyc, K_ST,  8'd0);
        expect_at(cyc, K_RDY, 8'd0);
        expect_at(cyc, K_BSY, 8'd0);
        expect_at(cyc, K_GR,  8'd0);
        expect_at(cyc, K_NC,  8'd0);
        rst     = 1'b0;
        nclk_in = 1'b0;

        // Power-up: stages at T+5, T+7, T+8; local clock period 4 during UP
        tick(1);
        c0  = cyc;
        req = 1'b1;
        expect_at(c0+1, K_ST,  8'd1);
        expect_at(c0+1, K_BSY, 8'd1);
        expect_at(c0+1, K_EN,  8'd0);
        expect_at(c0+3, K_GR,  8'd0);
        expect_at(c0+4, K_EN,  8'd0);
        expect_at(c0+5, K_EN,  8'd1);
        expect_at(c0+6, K_EN,  8'd1);
        expect_at(c0+7, K_EN,  8'd3);
        expect_at(c0+7, K_ST,  8'd1);
        expect_at(c0+7, K_BSY, 8'd1);
        expect_at(c0+8, K_EN,  8'd7);
        expect_at(c0+8, K_ST,  8'd2);
        expect_at(c0+8, K_RDY, 8'd1);
        expect_at(c0+8, K_BSY, 8'd0);
        expect_at(c0+8, K_GR,  8'd1);
        expect_at(c0+1, K_NC,  8'd0);
        expect_at(c0+2, K_NC,  8'd0);
        expect_at(c0+3, K_NC,  8'd1);
        expect_at(c0+4, K_NC,  8'd1);
        expect_at(c0+5, K_NC,  8'd0);
        expect_at(c0+6, K_NC,  8'd0);
        expect_at(c0+7, K_NC,  8'd1);

        // ON: host reset / clock pass through combinationally
        tick(9);
        grest_in = 1'b0;
        nclk_in  = 1'b1;
        expect_at(cyc, K_GR, 8'd0);
        expect_at(cyc, K_NC, 8'd1);
        tick(1);
        grest_in = 1'b1;
        nclk_in  = 1'b0;
        expect_at(cyc, K_GR, 8'd1);
        expect_at(cyc, K_NC, 8'd0);

        // Power-down from ON: 011 at U+2, 001 at U+4, 000 and OFF at U+8
        tick(1);
        u0  = cyc;
        req = 1'b0;
        expect_at(u0+1, K_ST,  8'd3);
        expect_at(u0+1, K_EN,  8'd7);
        expect_at(u0+1, K_RDY, 8'd0);
        expect_at(u0+1, K_BSY, 8'd1);
        expect_at(u0+1, K_GR,  8'd0);
        expect_at(u0+1, K_NC,  8'd1);
        expect_at(u0+2, K_EN,  8'd3);
        expect_at(u0+3, K_EN,  8'd3);
        expect_at(u0+4, K_EN,  8'd1);
        expect_at(u0+7, K_EN,  8'd1);
        expect_at(u0+7, K_ST,  8'd3);
        expect_at(u0+8, K_EN,  8'd0);
        expect_at(u0+8, K_ST,  8'd0);
        expect_at(u0+8, K_BSY, 8'd0);
        expect_at(u0+8, K_NC,  8'd0);

        // Abort after stage 0: request low sampled at T+7, all off at T+11
        tick(10);
        t0  = cyc;
        req = 1'b1;
        expect_at(t0+5, K_EN, 8'd1);
        tick(6);
        req = 1'b0;
        expect_at(t0+6,  K_ST, 8'd1);
        expect_at(t0+7,  K_ST, 8'd3);
        expect_at(t0+7,  K_EN, 8'd1);
        expect_at(t0+8,  K_EN, 8'd1);
        expect_at(t0+10, K_EN, 8'd1);
        expect_at(t0+11, K_EN, 8'd0);
        expect_at(t0+11, K_ST, 8'd0);

        // Reversal in DOWN after stage 2 cleared
        tick(7);
        r0  = cyc;
        req = 1'b1;
        expect_at(r0+8, K_EN, 8'd7);
        tick(9);
        u1  = cyc;
        req = 1'b0;
        tick(2);
        req = 1'b1;
        expect_at(u1+2, K_EN,  8'd3);
        expect_at(u1+2, K_ST,  8'd3);
        expect_at(u1+3, K_ST,  8'd1);
        expect_at(u1+3, K_EN,  8'd3);
        expect_at(u1+4, K_EN,  8'd7);
        expect_at(u1+4, K_ST,  8'd2);
        expect_at(u1+4, K_RDY, 8'd1);

        // Back to OFF, then reset during UP with 011 set
        tick(3);
        req = 1'b0;
        expect_at(u1+17, K_ST, 8'd0);
        tick(14);
        v0  = cyc;
        req = 1'b1;
        expect_at(v0+7, K_EN, 8'd3);
        expect_at(v0+7, K_ST, 8'd1);
        tick(7);
        rst = 1'b1;
        expect_at(v0+8, K_EN,  8'd0);
        expect_at(v0+8, K_ST,  8'd0);
        expect_at(v0+8, K_NC,  8'd0);
        expect_at(v0+8, K_GR,  8'd0);
        expect_at(v0+8, K_BSY, 8'd0);
        tick(1);
        rst = 1'b0;
        req = 1'b0;
        expect_at(v0+9, K_ST, 8'd0);
        expect_at(v0+9, K_EN, 8'd0);

        // Request dropped in UP before any stage: straight to OFF
        tick(2);
        w0  = cyc;
        req = 1'b1;
        tick(2);
        req = 1'b0;
        expect_at(w0+2, K_ST,  8'd1);
        expect_at(w0+3, K_ST,  8'd0);
        expect_at(w0+3, K_BSY, 8'd0);
        expect_at(w0+3, K_EN,  8'd0);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 50 && sb.size() > 0; i++) tick(1);
        if (sb.size() > 0) begin
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
            n_vec += sb.size();
            n_bad += sb.size();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
